// File: rtl/capture_ctrl.sv
// Capture run controller: waits for a trigger edge after arm, then gates source
// samples into a FIFO until the programmed length is written, counting drops.
module capture_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk100M_i,
  input  logic                 clk100M_resetn_i,
  input  logic                 arm_i,
  input  logic                 abort_i,
  input  logic                 trigger_i,
  input  logic [CNT_WIDTH-1:0] capture_len_i,
  input  logic                 sample_valid_i,
  input  logic                 fifoFull_i,
  output logic                 capture_en_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overflow_o,
  output logic [CNT_WIDTH-1:0] sample_cnt_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } stateT;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  stateT                state;
  logic [CNT_WIDTH-1:0] lenLatch;
  logic [CNT_WIDTH-1:0] sampleCnt;
  logic [CNT_WIDTH-1:0] dropCnt;
  logic [CNT_WIDTH-1:0] sampleCntNext;
  logic                 overflow;
  logic                 trigDly;
  logic                 trigEdge;
  logic                 dropNow;
  logic                 lastWrite;

  // Abort wins over a pending write or drop in the cycle it arrives.
  assign trigEdge      = trigger_i & ~trigDly;
  assign capture_en_o  = (state == CAPTURE) & sample_valid_i & ~fifoFull_i & ~abort_i;
  assign dropNow       = (state == CAPTURE) & sample_valid_i & fifoFull_i & ~abort_i;
  assign sampleCntNext = sampleCnt + CNT_ONE;
  assign lastWrite     = capture_en_o & (sampleCntNext == lenLatch);

  assign busy_o       = (state != IDLE);
  assign done_o       = (state == DONE);
  assign state_o      = state;
  assign overflow_o   = overflow;
  assign sample_cnt_o = sampleCnt;
  assign drop_cnt_o   = dropCnt;

  always_ff @(posedge clk100M_i or negedge clk100M_resetn_i) begin
    if (!clk100M_resetn_i) begin
      state     <= IDLE;
      lenLatch  <= '0;
      sampleCnt <= '0;
      dropCnt   <= '0;
      overflow  <= 1'b0;
      trigDly   <= 1'b0;
    end else begin
      trigDly <= trigger_i;
      case (state)
        IDLE: begin
          if (arm_i && !abort_i) begin
            sampleCnt <= '0;
            dropCnt   <= '0;
            overflow  <= 1'b0;
            if (capture_len_i != '0) begin
              lenLatch <= capture_len_i;
              state    <= ARMED;
            end else begin
              state <= DONE;
            end
          end
        end
        ARMED: begin
          if (abort_i) begin
            state <= IDLE;
          end else if (trigEdge) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (abort_i) begin
            state <= IDLE;
          end else begin
            if (capture_en_o) begin
              sampleCnt <= sampleCntNext;
            end
            if (lastWrite) begin
              state <= DONE;
            end
            // Drop counter saturates so a long stall never wraps back to a small value.
            if (dropNow) begin
              overflow <= 1'b1;
              if (dropCnt != '1) begin
                dropCnt <= dropCnt + CNT_ONE;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a cycle-level behavioural model.
module tb_capture_ctrl;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk   = 1'b0;
  logic         rstN  = 1'b0;
  logic         arm   = 1'b0;
  logic         abort = 1'b0;
  logic         trig  = 1'b0;
  logic         valid = 1'b0;
  logic         full  = 1'b0;
  logic [W-1:0] len   = '0;

  logic         captureEn;
  logic         busy;
  logic         done;
  logic         overflow;
  logic [W-1:0] sampleCnt;
  logic [W-1:0] dropCnt;
  logic [1:0]   stateOut;

  capture_ctrl #(.CNT_WIDTH(W)) dut (
    .clk100M_i        (clk),
    .clk100M_resetn_i (rstN),
    .arm_i            (arm),
    .abort_i          (abort),
    .trigger_i        (trig),
    .capture_len_i    (len),
    .sample_valid_i   (valid),
    .fifoFull_i       (full),
    .capture_en_o     (captureEn),
    .busy_o           (busy),
    .done_o           (done),
    .overflow_o       (overflow),
    .sample_cnt_o     (sampleCnt),
    .drop_cnt_o       (dropCnt),
    .state_o          (stateOut)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;
  int writesSeen  = 0;
  int doneSeen    = 0;

  // Reference model: 0 idle, 1 waiting for trigger, 2 capturing, 3 done.
  int mState;
  int mLen;
  int mCnt;
  int mDrop;
  bit mOvf;
  bit mTrigPrev;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mState = 0; mLen = 0; mCnt = 0; mDrop = 0; mOvf = 0; mTrigPrev = 0;
  endtask

  function automatic bit expWrite();
    return (mState == 2) && valid && !full && !abort;
  endfunction

  task automatic modelStep();
    bit wr;
    bit rise;
    wr   = expWrite();
    rise = trig && !mTrigPrev;
    case (mState)
      0: if (arm && !abort) begin
           mCnt = 0; mDrop = 0; mOvf = 0;
           if (len != 0) begin mLen = int'(len); mState = 1; end
           else mState = 3;
         end
      1: if (abort) mState = 0; else if (rise) mState = 2;
      2: if (abort) mState = 0;
         else if (wr) begin
           mCnt = mCnt + 1;
           if (mCnt == mLen) mState = 3;
         end else if (valid && full) begin
           mOvf  = 1;
           mDrop = (mDrop + 1 > MAXV) ? MAXV : mDrop + 1;
         end
      default: mState = 0;
    endcase
    mTrigPrev = trig;
  endtask

  task automatic checkAll(input string ph);
    checkOutput({ph, "_state"},    32'(stateOut),  32'(mState));
    checkOutput({ph, "_busy"},     32'(busy),      32'(mState != 0));
    checkOutput({ph, "_done"},     32'(done),      32'(mState == 3));
    checkOutput({ph, "_en"},       32'(captureEn), 32'(expWrite()));
    checkOutput({ph, "_sampleCnt"}, 32'(sampleCnt), 32'(mCnt));
    checkOutput({ph, "_dropCnt"},  32'(dropCnt),   32'(mDrop));
    checkOutput({ph, "_overflow"}, 32'(overflow),  32'(mOvf));
  endtask

  task automatic applyStimulus(input string ph, input logic a, input logic ab, input logic t,
                               input logic v, input logic f, input int l);
    @(negedge clk);
    arm = a; abort = ab; trig = t; valid = v; full = f; len = W'(l);
    #1;
    checkAll(ph);
    if (captureEn === 1'b1) writesSeen++;
    if (done === 1'b1) doneSeen++;
    modelStep();
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rstN = 1'b1;
    arm = 0; abort = 0; trig = 0; valid = 0; full = 0; len = '0;
    #1;
    checkAll("release");
    modelStep();
  endtask

  initial begin
    $display("[TB] capture_ctrl bench start");
    modelReset();
    valid = 1'b1;
    #3;
    checkAll("reset");
    releaseReset();

    // Basic run of four samples.
    writesSeen = 0; doneSeen = 0;
    applyStimulus("r35", 1, 0, 0, 0, 0, 4);
    applyStimulus("r35", 0, 0, 0, 1, 0, 4);
    for (int i = 0; i < 8; i++) applyStimulus("r35", 0, 0, 1, 1, 0, 4);
    checkOutput("r35_writes", 32'(writesSeen), 32'd4);
    checkOutput("r35_donePulses", 32'(doneSeen), 32'd1);

    // Eight samples with a three-cycle full stall.
    writesSeen = 0; doneSeen = 0;
    applyStimulus("r36", 1, 0, 0, 0, 0, 8);
    applyStimulus("r36", 0, 0, 1, 1, 0, 8);
    for (int i = 0; i < 14; i++) applyStimulus("r36", 0, 0, 1, 1, (i >= 3 && i < 6), 8);
    checkOutput("r36_writes", 32'(writesSeen), 32'd8);
    checkOutput("r36_drops", 32'(dropCnt), 32'd3);
    checkOutput("r36_overflow", 32'(overflow), 32'd1);
    checkOutput("r36_donePulses", 32'(doneSeen), 32'd1);

    // Trigger already high at arm must not count as an edge.
    writesSeen = 0; doneSeen = 0;
    applyStimulus("r37", 0, 0, 1, 0, 0, 2);
    applyStimulus("r37", 1, 0, 1, 0, 0, 2);
    for (int i = 0; i < 3; i++) applyStimulus("r37", 0, 0, 1, 1, 0, 2);
    checkOutput("r37_heldState", 32'(stateOut), 32'd1);
    checkOutput("r37_heldWrites", 32'(writesSeen), 32'd0);
    applyStimulus("r37", 0, 0, 0, 1, 0, 2);
    for (int i = 0; i < 5; i++) applyStimulus("r37", 0, 0, 1, 1, 0, 2);
    checkOutput("r37_writes", 32'(writesSeen), 32'd2);

    // Abort after two of five writes.
    writesSeen = 0; doneSeen = 0;
    applyStimulus("r38", 1, 0, 0, 0, 0, 5);
    applyStimulus("r38", 0, 0, 1, 1, 0, 5);
    applyStimulus("r38", 0, 0, 1, 1, 0, 5);
    applyStimulus("r38", 0, 0, 1, 1, 0, 5);
    applyStimulus("r38", 0, 1, 1, 1, 0, 5);
    for (int i = 0; i < 3; i++) applyStimulus("r38", 0, 0, 1, 1, 0, 5);
    checkOutput("r38_writes", 32'(writesSeen), 32'd2);
    checkOutput("r38_donePulses", 32'(doneSeen), 32'd0);
    checkOutput("r38_sampleCnt", 32'(sampleCnt), 32'd2);

    // Zero length goes straight to done; arm with abort is ignored.
    writesSeen = 0; doneSeen = 0;
    applyStimulus("r39", 1, 0, 0, 1, 0, 0);
    applyStimulus("r39", 0, 0, 0, 1, 0, 0);
    applyStimulus("r39", 0, 0, 0, 1, 0, 0);
    checkOutput("r39_donePulses", 32'(doneSeen), 32'd1);
    checkOutput("r39_writes", 32'(writesSeen), 32'd0);
    applyStimulus("r39", 1, 1, 0, 0, 0, 3);
    applyStimulus("r39", 0, 0, 0, 0, 0, 3);
    checkOutput("r39_armAbortState", 32'(stateOut), 32'd0);

    // Long stall saturates the drop counter.
    applyStimulus("sat", 1, 0, 0, 0, 0, 2);
    applyStimulus("sat", 0, 0, 1, 1, 0, 2);
    for (int i = 0; i < 20; i++) applyStimulus("sat", 0, 0, 1, 1, 1, 2);
    for (int i = 0; i < 4; i++) applyStimulus("sat", 0, 0, 1, 1, 0, 2);
    checkOutput("sat_dropCnt", 32'(dropCnt), 32'(MAXV));

    // Asynchronous reset in the middle of a capture.
    applyStimulus("r40", 1, 0, 0, 0, 0, 6);
    applyStimulus("r40", 0, 0, 1, 1, 0, 6);
    for (int i = 0; i < 3; i++) applyStimulus("r40", 0, 0, 1, 1, 0, 6);
    @(negedge clk);
    valid = 1; full = 0; trig = 1;
    #2;
    rstN = 1'b0;
    #1;
    modelReset();
    checkAll("r40_async");
    checkOutput("r40_enNoEdge", 32'(captureEn), 32'd0);
    releaseReset();
    for (int i = 0; i < 3; i++) applyStimulus("r40_after", 0, 0, i[0], 1, 0, 6);
    checkOutput("r40_stayIdle", 32'(stateOut), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic a, ab, t, v, f;
      a  = ($urandom_range(0, 7) == 0);
      ab = ($urandom_range(0, 39) == 0);
      t  = ($urandom_range(0, 3) == 0) ? ~trig : trig;
      v  = ($urandom_range(0, 3) != 0);
      f  = ab ? 1'b0 : ($urandom_range(0, 3) == 0);
      applyStimulus("rand", a, ab, t, v, f, int'($urandom_range(0, 6)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
